uart_rx_marco: RTL and testbench
================================

UART_RX_MARCO -- requirements
Module: uart_rx_marco

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL be updated on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port os_tick, input, 1 bit: one-clk pulse at 16x the baud rate (9600 x 16).
REQ-004 The block SHALL have port rx, input, 1 bit: asynchronous UART line, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port data, output, 8 bits: last correctly framed byte, held until the next good byte.
REQ-006 The block SHALL have port data_valid, output, 1 bit: one-clk pulse when data is updated.
REQ-007 The block SHALL have port frame_err, output, 1 bit: one-clk pulse when a stop bit samples low.
REQ-008 The block SHALL have port marco_detected, output, 1 bit: one-clk pulse on receipt of the complete sequence "MARCO\n".
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value rx_s only.
REQ-011 The FSM SHALL have the states IDLE, START, DATA, STOP and BREAK, with a 4-bit oversample counter os_cnt and a 3-bit bit counter.
REQ-012 IDLE: when rx_s==0 on an os_tick, the FSM SHALL go to START with os_cnt=0.
REQ-013 START: os_cnt SHALL increment on each os_tick; at the tick where os_cnt==7 (mid start bit), rx_s==0 SHALL go to DATA with os_cnt=0, otherwise it SHALL return to IDLE as a glitch, with no output pulse.
REQ-014 DATA: on the os_tick where os_cnt==15, rx_s SHALL be shifted into bit[7] of the shift register (right shift, LSB first) and os_cnt SHALL wrap to 0; after the 8th bit the FSM SHALL go to STOP.
REQ-015 STOP: on the os_tick where os_cnt==15, rx_s==1 SHALL load data from the shift register, pulse data_valid and go to IDLE; rx_s==0 SHALL pulse frame_err, leave data unchanged and go to BREAK.
REQ-016 BREAK: the FSM SHALL stay in BREAK until rx_s==1 on an os_tick, then go to IDLE; a held-low line SHALL yield exactly one frame_err.
REQ-017 data_valid and frame_err SHALL assert in the clk cycle after the sampling os_tick, be mutually exclusive, and never exceed one cycle.
REQ-018 Clock cycles with os_tick low SHALL change no state other than the synchronizer.
REQ-019 Matcher: a 3-bit index 0..5 SHALL track the expected byte sequence 4D 41 52 43 4F 0A, evaluated only on good bytes.
REQ-020 On a good byte equal to expected[index], index SHALL increment; at index 5, marco_detected SHALL pulse in the same cycle as data_valid and index SHALL return to 0.
REQ-021 On a mismatching good byte, index SHALL become 1 if the byte is 0x4D, else 0.
REQ-022 A frame_err SHALL clear index to 0.

Reset
REQ-023 rst_n low SHALL immediately force: state=IDLE, os_cnt=0, bit counter=0, shift register=0x00, data=0x00, data_valid=0, frame_err=0, marco_detected=0, busy=0, match index=0, and both synchronizer flops=1.
REQ-024 A reset asserted mid-frame SHALL discard the partial byte; after release, reception SHALL resume only on a new falling edge seen in IDLE.

Configuration
REQ-025 With macro UART_RX_MARCO_MATCH_EN defined, the matcher (REQ-019..REQ-022) SHALL be compiled in.
REQ-026 Without UART_RX_MARCO_MATCH_EN, no matcher logic SHALL exist, marco_detected SHALL be tied 0, and all other behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL send byte 0xA5 at 16 os_ticks/bit -> exactly one data_valid, data==0xA5, frame_err never asserted, busy low afterwards.
REQ-028 The bench SHALL send "MARCO\n" back-to-back -> six data_valid pulses and marco_detected coinciding with the 0x0A data_valid only (macro defined); with the macro undefined, marco_detected SHALL stay 0.
REQ-029 The bench SHALL send "MMARCO\n" and "MARXMARCO\n" -> exactly one marco_detected per string.
REQ-030 The bench SHALL drive rx low for 4 os_ticks then high -> START aborts at os_cnt==7, return to IDLE, no data_valid or frame_err.
REQ-031 The bench SHALL send 0x3C with the stop bit low, then hold rx low for 40 bit times -> one frame_err, data keeps its prior value, FSM in BREAK until rx high, and the next byte 0x4D is received correctly.
REQ-032 The bench SHALL assert rst_n low during data bit 4 of 0x55, then release -> all outputs at reset values, the next full byte 0x0F received correctly, and the match index starting from 0.

Source files
------------

// File: rtl/uart_rx_marco_if.sv
// Signal bundle between the oversample/line source and the UART receiver.
interface uart_rx_marco_if;
    logic       os_tick;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       marco_detected;
    logic       busy;

    modport master (
        output os_tick, rx,
        input  data, data_valid, frame_err, marco_detected, busy
    );

    modport slave (
        input  os_tick, rx,
        output data, data_valid, frame_err, marco_detected, busy
    );
endinterface

// File: rtl/uart_rx_marco.sv
// 8N1 UART receiver at 16x oversampling with an optional "MARCO\n" sequence matcher.
// Define UART_RX_MARCO_MATCH_EN to build the matcher; otherwise marco_detected is tied low.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low on an os_tick
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits, one every 16 os_ticks, LSB first
// STOP  | sampling the stop bit; good byte or framing error
// BREAK | stop bit was low; waiting for the line to return high
module uart_rx_marco (
    input  logic            clk,
    input  logic            rst_n,
    uart_rx_marco_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t     state;
    logic       rx_meta;
    logic       rx_s;
    logic [3:0] os_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] data_r;
    logic       data_valid_r;
    logic       frame_err_r;

`ifdef UART_RX_MARCO_MATCH_EN
    logic [2:0] match_idx;
    logic       marco_r;

    function automatic logic [7:0] marco_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    marco_byte = 8'h4D;
            3'd1:    marco_byte = 8'h41;
            3'd2:    marco_byte = 8'h52;
            3'd3:    marco_byte = 8'h43;
            3'd4:    marco_byte = 8'h4F;
            default: marco_byte = 8'h0A;
        endcase
    endfunction

    assign bus.marco_detected = marco_r;
`else
    assign bus.marco_detected = 1'b0;
`endif

    assign bus.data       = data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.busy       = (state != IDLE);

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            os_cnt       <= 4'd0;
            bit_cnt      <= 3'd0;
            shift_reg    <= 8'h00;
            data_r       <= 8'h00;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef UART_RX_MARCO_MATCH_EN
            match_idx    <= 3'd0;
            marco_r      <= 1'b0;
`endif
        end else begin
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef UART_RX_MARCO_MATCH_EN
            marco_r      <= 1'b0;
`endif
            if (bus.os_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state  <= START;
                            os_cnt <= 4'd0;
                        end
                    end
                    START: begin
                        if (os_cnt == 4'd7) begin
                            os_cnt  <= 4'd0;
                            bit_cnt <= 3'd0;
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            os_cnt <= os_cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (os_cnt == 4'd15) begin
                            os_cnt    <= 4'd0;
                            shift_reg <= {rx_s, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= STOP;
                        end else begin
                            os_cnt <= os_cnt + 4'd1;
                        end
                    end
                    STOP: begin
                        if (os_cnt == 4'd15) begin
                            os_cnt <= 4'd0;
                            if (rx_s) begin
                                data_r       <= shift_reg;
                                data_valid_r <= 1'b1;
                                state        <= IDLE;
`ifdef UART_RX_MARCO_MATCH_EN
                                if (shift_reg == marco_byte(match_idx)) begin
                                    if (match_idx == 3'd5) begin
                                        marco_r   <= 1'b1;
                                        match_idx <= 3'd0;
                                    end else begin
                                        match_idx <= match_idx + 3'd1;
                                    end
                                end else begin
                                    // A stray 'M' may itself begin a new sequence.
                                    match_idx <= (shift_reg == 8'h4D) ? 3'd1 : 3'd0;
                                end
`endif
                            end else begin
                                frame_err_r <= 1'b1;
                                state       <= BREAK;
`ifdef UART_RX_MARCO_MATCH_EN
                                match_idx   <= 3'd0;
`endif
                            end
                        end else begin
                            os_cnt <= os_cnt + 4'd1;
                        end
                    end
                    BREAK: begin
                        if (rx_s)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_marco.sv
// Directed self-checking bench for uart_rx_marco; os_tick pulses every second clk.
module tb_uart_rx_marco;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    int   dv_cnt;
    int   fe_cnt;
    int   marco_cnt;
    int   bad_cnt;
    logic dv_prev;
    logic fe_prev;
    int   exp_m;
    int   s_dv, s_fe, s_m;

    uart_rx_marco_if bus ();

    uart_rx_marco dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        logic [31:0] div;
        div = 0;
        bus.os_tick = 1'b0;
        forever begin
            @(negedge clk);
            div = div + 1;
            bus.os_tick = div[0];
        end
    end

    // Pulse counters and protocol sanity, sampled on the falling edge.
    initial begin
        dv_cnt = 0; fe_cnt = 0; marco_cnt = 0; bad_cnt = 0;
        dv_prev = 1'b0; fe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.data_valid === 1'b1) dv_cnt++;
            if (bus.frame_err === 1'b1) fe_cnt++;
            if (bus.marco_detected === 1'b1) begin
                marco_cnt++;
                if (!(bus.data_valid === 1'b1 && bus.data === 8'h0A)) bad_cnt++;
            end
            if (bus.data_valid === 1'b1 && bus.frame_err === 1'b1) bad_cnt++;
            if (dv_prev === 1'b1 && bus.data_valid === 1'b1) bad_cnt++;
            if (fe_prev === 1'b1 && bus.frame_err === 1'b1) bad_cnt++;
            dv_prev = bus.data_valid;
            fe_prev = bus.frame_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (bus.os_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    // Leaves rx at the stop level; callers restore the idle line.
    task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
        bus.rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            wait_ticks(16);
        end
        bus.rx = stop_lvl;
        wait_ticks(16);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        bus.rx = 1'b1;
        wait_ticks(4);
    endtask

    task automatic snap();
        s_dv = dv_cnt; s_fe = fe_cnt; s_m = marco_cnt;
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef UART_RX_MARCO_MATCH_EN
        exp_m = 1;
`else
        exp_m = 0;
`endif
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", bus.data, 8'h00);
        check("reset_dv", bus.data_valid, 1'b0);
        check("reset_fe", bus.frame_err, 1'b0);
        check("reset_marco", bus.marco_detected, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(8);

        // Single byte 0xA5
        snap();
        send_byte(8'hA5, 1'b1);
        wait_ticks(4);
        check("a5_dv_count", dv_cnt - s_dv, 1);
        check("a5_data", bus.data, 8'hA5);
        check("a5_no_fe", fe_cnt - s_fe, 0);
        check("a5_busy_low", bus.busy, 1'b0);

        // Back-to-back "MARCO\n"
        snap();
        send_str("MARCO\n");
        check("marco_dv_count", dv_cnt - s_dv, 6);
        check("marco_count", marco_cnt - s_m, exp_m);
        check("marco_data", bus.data, 8'h0A);

        snap();
        send_str("MMARCO\n");
        check("mmarco_count", marco_cnt - s_m, exp_m);
        check("mmarco_dv_count", dv_cnt - s_dv, 7);

        snap();
        send_str("MARXMARCO\n");
        check("marx_count", marco_cnt - s_m, exp_m);

        // Start-bit glitch: low for 4 ticks only
        snap();
        bus.rx = 1'b0;
        wait_ticks(4);
        check("glitch_busy_in_start", bus.busy, 1'b1);
        bus.rx = 1'b1;
        wait_ticks(24);
        check("glitch_busy_low", bus.busy, 1'b0);
        check("glitch_no_dv", dv_cnt - s_dv, 0);
        check("glitch_no_fe", fe_cnt - s_fe, 0);

        // Framing error then 40 bit times of break
        snap();
        send_byte(8'h3C, 1'b0);
        wait_ticks(640);
        check("break_fe_count", fe_cnt - s_fe, 1);
        check("break_no_dv", dv_cnt - s_dv, 0);
        check("break_data_kept", bus.data, 8'h0A);
        check("break_busy", bus.busy, 1'b1);
        bus.rx = 1'b1;
        wait_ticks(6);
        check("break_exit_idle", bus.busy, 1'b0);
        snap();
        send_str("M");
        check("after_break_data", bus.data, 8'h4D);
        check("after_break_dv", dv_cnt - s_dv, 1);

        // Reset during data bit 4 of 0x55
        send_str("MARC");
        bus.rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            bus.rx = i[0] ? 1'b0 : 1'b1;
            wait_ticks(16);
        end
        bus.rx = 1'b1;
        wait_ticks(8);
        rst_n = 1'b0;
        #2;
        check("midrst_data", bus.data, 8'h00);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_dv", bus.data_valid, 1'b0);
        check("midrst_fe", bus.frame_err, 1'b0);
        check("midrst_marco", bus.marco_detected, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(200);
        check("midrst_stay_idle", bus.busy, 1'b0);
        snap();
        send_byte(8'h0F, 1'b1);
        bus.rx = 1'b1;
        wait_ticks(4);
        check("postrst_data", bus.data, 8'h0F);
        check("postrst_dv", dv_cnt - s_dv, 1);
        check("postrst_no_fe", fe_cnt - s_fe, 0);
        snap();
        send_str("MARCO\n");
        check("postrst_marco", marco_cnt - s_m, exp_m);

        // Reset must clear a partially matched sequence
        send_str("MARC");
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(4);
        snap();
        send_str("O\n");
        check("rst_clears_index", marco_cnt - s_m, 0);
        check("rst_clears_index_dv", dv_cnt - s_dv, 2);

        check("pulse_protocol", bad_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
